i2c_addr_master: RTL and testbench
==================================

I2C_ADDR_MASTER -- requirements
Module: i2c_addr_master

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 7; width of the target slave address.
REQ-002 Parameter HALF_PERIOD, default 4; clk cycles per SCL half period; legal range 2..255.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_req  input  1  request to run one address transaction; level-sampled.
REQ-006 target_addr  input  ADDRESS_WIDTH  slave address; latched on acceptance.
REQ-007 rw_bit  input  1  R/W bit sent after the address; latched on acceptance.
REQ-008 SDA_in  input  1  bus SDA as seen by the master; sampled in the ACK slot.
REQ-009 SCL_out  output  1  generated SCL.
REQ-010 SDA_out  output  1  driven SDA; 1 = released/high.
REQ-011 busy  output  1  high from the cycle after acceptance until the return to IDLE.
REQ-012 done  output  1  one-cycle pulse on completion.
REQ-013 ack_ok  output  1  1 = slave ACKed (SDA_in low in the ACK slot); valid from done, held until next acceptance.

Function
REQ-014 The FSM SHALL have states IDLE, START, BIT, ACK, STOP; each phase lasts exactly HALF_PERIOD clk cycles, timed by a tick counter that restarts on every phase change.
REQ-015 IDLE: SCL_out=1, SDA_out=1, busy=0; start_req=1 SHALL be accepted, latching byte={target_addr,rw_bit}, and the FSM SHALL enter START on the next edge.
REQ-016 start_req while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-017 START: phase 1 SDA_out=0, SCL_out=1; phase 2 SDA_out=0, SCL_out=0; then BIT.
REQ-018 BIT: for i=7 down to 0, low phase (SCL_out=0, SDA_out=byte[i]) then high phase (SCL_out=1, SDA_out unchanged); SDA_out SHALL change only while SCL_out=0.
REQ-019 A 3-bit bit counter SHALL decrement after each high phase; after bit 0 the FSM SHALL enter ACK.
REQ-020 ACK: SDA_out=1 in both phases; low phase then high phase; SDA_in SHALL be sampled in the last clk of the high phase; ack_ok=~sample.
REQ-021 STOP: phase 1 SCL_out=0, SDA_out=0; phase 2 SCL_out=1, SDA_out=0; phase 3 SCL_out=1, SDA_out=1; then IDLE.
REQ-022 The STOP sequence SHALL be issued after both ACK and NACK.
REQ-023 A transaction SHALL occupy 23*HALF_PERIOD cycles after acceptance; done SHALL pulse in the first IDLE cycle, 23*HALF_PERIOD+1 cycles after the accept cycle.
REQ-024 In the done cycle a new start_req SHALL be accepted (back-to-back permitted).
REQ-025 SCL_out and SDA_out SHALL be registered outputs (glitch-free).

Reset
REQ-026 On rst=1 at any edge, including mid-transaction: state=IDLE, SCL_out=1, SDA_out=1, busy=0, done=0, ack_ok=0, counters=0; no STOP SHALL be generated.
REQ-027 rst SHALL take priority over start_req in the same cycle.

Structure
REQ-028 Package i2c_pkg SHALL hold the state enum, ADDRESS_WIDTH default, and the phase-count constants (START=2, BIT=16, ACK=2, STOP=3 half periods).
REQ-029 One sub-module, i2c_scl_tick, SHALL hold the HALF_PERIOD tick counter with a clear input; the FSM stays in i2c_addr_master.

Verification
REQ-030 HALF_PERIOD=4, target_addr=7'h10, rw_bit=1, SDA_in=0 in the ACK slot -> bits 0x21 MSB-first on SDA_out, ack_ok=1, done at cycle 93.
REQ-031 target_addr=7'h11, rw_bit=0, SDA_in held 1 -> byte 0x22 sent, ack_ok=0, STOP still issued, done at cycle 93.
REQ-032 rst pulsed during bit 4 -> next cycle SCL_out=1, SDA_out=1, busy=0; no done pulse.
REQ-033 start_req held continuously -> second transaction accepted exactly in the done cycle; busy low for exactly one cycle.
REQ-034 start_req pulsed mid-transaction with a different address -> ignored; the original byte completes unchanged.
REQ-035 All runs: checker SHALL flag any SDA_out change while SCL_out=1, except START phase 1 and STOP phase 3.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and phase-count constants for the I2C address-phase master.
package i2c_pkg;

    localparam int ADDRESS_WIDTH_DEF = 7;

    // Length of each FSM segment, in SCL half periods.
    localparam int START_PHASES = 2;
    localparam int BIT_PHASES   = 16;
    localparam int ACK_PHASES   = 2;
    localparam int STOP_PHASES  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

endpackage

// File: rtl/i2c_scl_tick.sv
// Half-period timer: counts clk cycles within one SCL phase, restarted by clear.
module i2c_scl_tick #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic last
);

    localparam int CW = $clog2(HALF_PERIOD);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(HALF_PERIOD - 1));

endmodule

// File: rtl/i2c_addr_master.sv
// I2C master that issues START, one address+R/W byte, samples ACK, then STOP.
module i2c_addr_master
    import i2c_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int HALF_PERIOD   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_req,
    input  logic [ADDRESS_WIDTH-1:0] target_addr,
    input  logic                     rw_bit,
    input  logic                     SDA_in,
    output logic                     SCL_out,
    output logic                     SDA_out,
    output logic                     busy,
    output logic                     done,
    output logic                     ack_ok
);

    localparam int BW = ADDRESS_WIDTH + 1;

    state_t        state, state_d;
    logic [1:0]    phase, phase_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          ack_d, done_d, scl_d, sda_d;
    logic          last;

    // The timer restarts at every phase boundary and stays cleared while idle.
    i2c_scl_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear ((state == ST_IDLE) || last),
        .last  (last)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state;
        phase_d = phase;
        bit_d   = bit_cnt;
        byte_d  = byte_q;
        ack_d   = ack_ok;
        done_d  = 1'b0;

        unique case (state)
            ST_IDLE: if (start_req) begin
                state_d = ST_START;
                phase_d = '0;
                bit_d   = 3'(BW - 1);
                byte_d  = {target_addr, rw_bit};
            end
            ST_START: if (last) begin
                if (phase == 2'(START_PHASES - 1)) begin
                    state_d = ST_BIT;
                    phase_d = '0;
                end else begin
                    phase_d = phase + 2'd1;
                end
            end
            ST_BIT: if (last) begin
                if (phase == 2'(BIT_PHASES / 8 - 1)) begin
                    phase_d = '0;
                    bit_d   = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) state_d = ST_ACK;
                end else begin
                    phase_d = phase + 2'd1;
                end
            end
            ST_ACK: if (last) begin
                if (phase == 2'(ACK_PHASES - 1)) begin
                    state_d = ST_STOP;
                    phase_d = '0;
                    ack_d   = ~SDA_in;
                end else begin
                    phase_d = phase + 2'd1;
                end
            end
            ST_STOP: if (last) begin
                if (phase == 2'(STOP_PHASES - 1)) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin levels decoded from the next state so the flops present them glitch-free.
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            ST_START: begin
                scl_d = (phase_d == 2'd0);
                sda_d = 1'b0;
            end
            ST_BIT: begin
                scl_d = phase_d[0];
                sda_d = byte_d[bit_d];
            end
            ST_ACK:  scl_d = phase_d[0];
            ST_STOP: begin
                scl_d = (phase_d != 2'd0);
                sda_d = (phase_d == 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            byte_q  <= '0;
            SCL_out <= 1'b1;
            SDA_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            bit_cnt <= bit_d;
            byte_q  <= byte_d;
            SCL_out <= scl_d;
            SDA_out <= sda_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            ack_ok  <= ack_d;
        end
    end

endmodule

// File: tb/tb_i2c_addr_master.sv
// Self-checking bench: per-cycle expected pin waveform queued at acceptance and compared every cycle.
module tb_i2c_addr_master;

    localparam int HP = 4;

    typedef struct packed {
        logic scl;
        logic sda;
        logic busy;
        logic done;
        logic edge_ok;
        logic ack_slot;
        logic ack_lvl;
        logic is_done;
        logic ack;
    } exp_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic       ack_lvl;
        logic [7:0] exp_byte;
        logic       exp_ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_req = 1'b0;
    logic [6:0] target_addr = '0;
    logic       rw_bit = 1'b0;
    logic       SDA_in = 1'b1;
    logic       SCL_out, SDA_out, busy, done, ack_ok;

    i2c_addr_master #(.ADDRESS_WIDTH(7), .HALF_PERIOD(HP)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_req   (start_req),
        .target_addr (target_addr),
        .rw_bit      (rw_bit),
        .SDA_in      (SDA_in),
        .SCL_out     (SCL_out),
        .SDA_out     (SDA_out),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    vec_t       vecs[5];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         busy_low_cnt = 0;
    int         done_cnt = 0;
    logic       prev_scl = 1'b0;
    logic       prev_sda = 1'b0;
    logic       model_ack = 1'b0;

    // Values the next step() applies to the DUT and to the model.
    logic       rst_v = 1'b1;
    logic       req = 1'b0;
    logic [6:0] addr = '0;
    logic       rwb = 1'b0;
    logic       ack_lvl = 1'b1;
    logic [7:0] exp_byte = '0;
    logic       exp_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic void push_phase(logic scl, logic sda, logic slot, logic lvl, logic edge_first);
        exp_t e;
        for (int i = 0; i < HP; i++) begin
            e = '0;
            e.scl      = scl;
            e.sda      = sda;
            e.busy     = 1'b1;
            e.ack_slot = slot;
            e.ack_lvl  = lvl;
            e.edge_ok  = edge_first && (i == 0);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_txn(logic [7:0] b, logic ack, logic lvl);
        exp_t e;
        push_phase(1'b1, 1'b0, 1'b0, lvl, 1'b1);
        push_phase(1'b0, 1'b0, 1'b0, lvl, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            push_phase(1'b0, b[i], 1'b0, lvl, 1'b0);
            push_phase(1'b1, b[i], 1'b0, lvl, 1'b0);
        end
        push_phase(1'b0, 1'b1, 1'b1, lvl, 1'b0);
        push_phase(1'b1, 1'b1, 1'b1, lvl, 1'b0);
        push_phase(1'b0, 1'b0, 1'b0, lvl, 1'b0);
        push_phase(1'b1, 1'b0, 1'b0, lvl, 1'b0);
        push_phase(1'b1, 1'b1, 1'b0, lvl, 1'b1);
        e = '0;
        e.scl     = 1'b1;
        e.sda     = 1'b1;
        e.done    = 1'b1;
        e.is_done = 1'b1;
        e.ack     = ack;
        exp_q.push_back(e);
    endfunction

    // One clock cycle: compare outputs against the queue head, then drive inputs and advance the model.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '0;
            e.scl = 1'b1;
            e.sda = 1'b1;
        end
        check("pins_scl_sda_busy_done", {28'b0, SCL_out, SDA_out, busy, done},
              {28'b0, e.scl, e.sda, e.busy, e.done});
        if (prev_scl === 1'b1 && SCL_out === 1'b1 && !e.edge_ok)
            check("sda_stable_while_scl_high", {31'b0, SDA_out}, {31'b0, prev_sda});
        if (e.is_done) begin
            check("ack_ok_at_done", {31'b0, ack_ok}, {31'b0, e.ack});
            check("done_latency", cyc - accept_cyc, 23 * HP + 1);
            model_ack = e.ack;
        end else if (!e.busy) begin
            check("ack_ok_hold", {31'b0, ack_ok}, {31'b0, model_ack});
        end
        if (busy === 1'b0) busy_low_cnt++;
        if (done === 1'b1) done_cnt++;
        prev_scl = SCL_out;
        prev_sda = SDA_out;

        SDA_in      = e.ack_slot ? e.ack_lvl : 1'b1;
        rst         = rst_v;
        start_req   = req;
        target_addr = addr;
        rw_bit      = rwb;
        if (rst_v) begin
            exp_q.delete();
            model_ack = 1'b0;
        end else if (req && exp_q.size() == 0) begin
            push_txn(exp_byte, exp_ack, ack_lvl);
            accept_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle();
        while (exp_q.size() != 0) step();
    endtask

    task automatic load(input vec_t v);
        addr     = v.addr;
        rwb      = v.rw;
        ack_lvl  = v.ack_lvl;
        exp_byte = v.exp_byte;
        exp_ack  = v.exp_ack;
    endtask

    initial begin
        vecs[0] = '{7'h10, 1'b1, 1'b0, 8'h21, 1'b1};
        vecs[1] = '{7'h11, 1'b0, 1'b1, 8'h22, 1'b0};
        vecs[2] = '{7'h7F, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{7'h00, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{7'h55, 1'b0, 1'b1, 8'hAA, 1'b0};

        // Reset values.
        rst_v = 1'b1;
        run(3);
        rst_v = 1'b0;
        run(2);

        // Single transactions from the table.
        for (int i = 0; i < 5; i++) begin
            load(vecs[i]);
            req = 1'b1;
            step();
            req = 1'b0;
            wait_idle();
            run(2);
        end

        // Reset wins over a simultaneous start request.
        load(vecs[0]);
        rst_v = 1'b1;
        req   = 1'b1;
        step();
        rst_v = 1'b0;
        req   = 1'b0;
        run(3);

        // Reset in the middle of bit 4: bus released next cycle, no done pulse.
        done_cnt = 0;
        load(vecs[0]);
        req = 1'b1;
        step();
        req = 1'b0;
        run(33);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        run(4);
        check("no_done_after_abort", done_cnt, 0);

        // Start held high: second transaction accepted in the done cycle.
        load(vecs[1]);
        req = 1'b1;
        step();
        busy_low_cnt = 0;
        run(23 * HP + 2);
        check("b2b_busy_low_cycles", busy_low_cnt, 1);
        req = 1'b0;
        wait_idle();
        run(2);

        // Request with another address while busy is ignored.
        load(vecs[0]);
        req = 1'b1;
        step();
        req  = 1'b0;
        run(20);
        addr = 7'h55;
        rwb  = 1'b0;
        req  = 1'b1;
        step();
        req = 1'b0;
        wait_idle();
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
